// File: rtl/adder_pipe_n_bit_if.sv
// Operand/result handshake bundle for adder_pipe_n_bit.
// master = operand issuer and result consumer, slave = the adder itself.
interface adder_pipe_n_bit_if #(
    parameter int N = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/adder_pipe_n_bit.sv
// Pipelined N-bit add/subtract: one CHUNK-bit slice per stage, carry registered between stages.
// Optional macro ADDER_PIPE_SATURATE_EN clamps the result to the signed range on overflow.
module adder_pipe_n_bit #(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input logic               clk,
    input logic               rst_n,
    adder_pipe_n_bit_if.slave bus
);
    localparam int STAGES = N / CHUNK;

    if (N < 1 || CHUNK < 1 || (N % CHUNK) != 0) begin : g_paramCheck
        $error("adder_pipe_n_bit: N must be >= 1 and an integer multiple of CHUNK");
    end

    // Rank k holds the operands plus the low k slices of the result already computed.
    logic               r_v    [STAGES];
    logic [N-1:0]       r_a    [STAGES];
    logic [N-1:0]       r_b    [STAGES];
    logic [N-1:0]       r_s    [STAGES];
    logic               r_c    [STAGES];
    logic [CHUNK:0]     w_add  [STAGES];
    logic [N-1:0]       w_part [STAGES];

    logic               r_outValid;
    logic [N-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               w_advance;
    logic               w_ovf;
    logic [N-1:0]       w_result;

    assign w_advance     = bus.out_ready || !r_outValid;
    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_outValid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_add[k]  = {1'b0, r_a[k][k*CHUNK +: CHUNK]}
                      + {1'b0, r_b[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, r_c[k]};
            w_part[k] = r_s[k];
            w_part[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
        end
    end

    assign w_ovf = (r_a[STAGES-1][N-1] == r_b[STAGES-1][N-1])
                && (w_part[STAGES-1][N-1] != r_a[STAGES-1][N-1]);

`ifdef ADDER_PIPE_SATURATE_EN
    localparam logic [N-1:0] SAT_ALL = '1;
    localparam logic [N-1:0] SAT_MAX = SAT_ALL >> 1;
    localparam logic [N-1:0] SAT_MIN = ~SAT_MAX;

    assign w_result = !w_ovf              ? w_part[STAGES-1] :
                      r_a[STAGES-1][N-1] ? SAT_MIN : SAT_MAX;
`else
    assign w_result = w_part[STAGES-1];
`endif

    // Global stall: every rank, bubbles included, moves only when the output can drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_outValid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_advance) begin
            r_v[0] <= bus.in_valid;
            r_a[0] <= bus.a;
            r_b[0] <= bus.sub ? ~bus.b : bus.b;
            r_c[0] <= bus.sub | bus.cin;
            r_s[0] <= '0;
            for (int k = 1; k < STAGES; k++) begin
                r_v[k] <= r_v[k-1];
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
                r_s[k] <= w_part[k-1];
                r_c[k] <= w_add[k-1][CHUNK];
            end
            r_outValid <= r_v[STAGES-1];
            r_sum      <= w_result;
            r_cout     <= w_add[STAGES-1][CHUNK];
            r_ovf      <= w_ovf;
        end
    end
endmodule
